// File: rtl/cap_vramwr_pkg.sv
`default_nettype none
// ============================================================================
// cap_vramwr_pkg : shared states, frame-size table and helpers for the
//                  capture-path VRAM write master.
// Revision: 1.0
// ============================================================================
package cap_vramwr_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_VS   = 3'd1;
    localparam logic [2:0] ST_WAIT_FIFO = 3'd2;
    localparam logic [2:0] ST_ADDR      = 3'd3;
    localparam logic [2:0] ST_DATA      = 3'd4;
    localparam logic [2:0] ST_RESP      = 3'd5;

    localparam int BIDX_W = 20;
    localparam int PPF_W  = 21;

    function automatic logic [PPF_W-1:0] pix_per_frame(input logic [1:0] resol);
        case (resol)
            2'd0:    return 21'd307200;
            2'd1:    return 21'd480000;
            2'd2:    return 21'd786432;
            default: return 21'd1310720;
        endcase
    endfunction

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cap_vsync_edge.sv
`default_nettype none
// ============================================================================
// cap_vsync_edge : two-flop synchroniser for the async VSYNC input followed
//                  by a rising-edge detector on the synchronised value.
// Revision: 1.0
// ============================================================================
module cap_vsync_edge
    import cap_vramwr_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic edge_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], async_i};
        end
    end

    assign edge_o = sync_q[1] & ~sync_q[2];

endmodule
`default_nettype wire

// File: rtl/cap_vramwr_mc.sv
`default_nettype none
// ============================================================================
// cap_vramwr_mc : AXI4 write master draining the capture FIFO into VRAM in
//                 fixed INCR bursts, rotating over NBUF frame buffers.
// Revision: 1.0
// ============================================================================
module cap_vramwr_mc
    import cap_vramwr_pkg::*;
#(
    parameter int          DATA_W      = 64,
    parameter int          ADDR_W      = 32,
    parameter int          BURST_LEN   = 16,
    parameter int          CNT_W       = 11,
    parameter int          NBUF        = 2,
    parameter logic [31:0] BUF_STRIDE  = 32'h0080_0000,
    // Divides the pixel count by 2**FRAME_SHIFT; 0 gives real video frames.
    parameter int          FRAME_SHIFT = 0
) (
    input  logic                       ACLK,
    input  logic                       ARST,
    input  logic [1:0]                 RESOL,
    input  logic                       CAPON,
    input  logic [ADDR_W-1:0]          CAPADDR,
    input  logic                       VSYNC,
    output logic [ADDR_W-1:0]          AWADDR,
    output logic [7:0]                 AWLEN,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [DATA_W-1:0]          WDATA,
    output logic [DATA_W/8-1:0]        WSTRB,
    output logic                       WVALID,
    input  logic                       WREADY,
    output logic                       WLAST,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY,
    input  logic [24*(DATA_W/32)-1:0]  FIFO_DOUT,
    input  logic [CNT_W-1:0]           FIFO_DATA_CNT,
    output logic                       FIFO_RD,
    input  logic                       CLR_ERR,
    output logic                       FRAME_DONE,
    output logic [1:0]                 CUR_BUF,
    output logic [1:0]                 LAST_BUF,
    output logic                       BUSY,
    output logic                       OVERRUN,
    output logic                       BRESP_ERR
);

    localparam int                PPB          = DATA_W / 32;
    localparam int                BURST_BYTES  = BURST_LEN * DATA_W / 8;
    localparam int                LOG2_BB      = clog2(BURST_BYTES);
    localparam int                NB_SHIFT     = clog2(PPB) + clog2(BURST_LEN) + FRAME_SHIFT;
    localparam logic [7:0]        C_BEAT_LAST  = 8'(BURST_LEN - 1);
    localparam logic [CNT_W:0]    C_FIFO_NEED  = (CNT_W + 1)'(BURST_LEN);
    localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ~ADDR_W'(BURST_BYTES - 1);
    localparam logic [1:0]        C_BUF_MAX    = 2'(NBUF - 1);

    logic [2:0]        state_q, state_d;
    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [BIDX_W-1:0] nburst_q, nburst_d;
    logic [7:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [1:0]        cur_buf_q, cur_buf_d;
    logic [1:0]        last_buf_q, last_buf_d;
    logic              frame_done_q, frame_done_d;
    logic              restart_q, restart_d;
    logic              overrun_q, overrun_d;
    logic              bresp_err_q, bresp_err_d;

    logic              w_edge;
    logic [PPF_W-1:0]  w_ppf;
    logic [BIDX_W-1:0] w_nburst;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_burst_addr;
    logic [1:0]        w_next_buf;
    logic              w_last_burst;
    logic              w_in_frame;
    logic              w_final_accept;
    logic              w_overrun_evt;
    logic              w_bresp_evt;
    logic              w_wvalid;
    logic [DATA_W-1:0] w_wdata_packed;

    cap_vsync_edge u_vsync_edge (
        .clk_i   (ACLK),
        .rst_i   (ARST),
        .async_i (VSYNC),
        .edge_o  (w_edge)
    );

    assign w_ppf        = pix_per_frame(RESOL);
    assign w_nburst     = BIDX_W'(w_ppf >> NB_SHIFT);
    assign w_base       = (CAPADDR & C_ALIGN_MASK) + ADDR_W'(cur_buf_q) * ADDR_W'(BUF_STRIDE);
    assign w_burst_addr = w_base + (ADDR_W'(bidx_q) << LOG2_BB);
    assign w_next_buf   = (cur_buf_q == C_BUF_MAX) ? 2'd0 : cur_buf_q + 2'd1;
    assign w_last_burst = (bidx_q == nburst_q - BIDX_W'(1));

    assign w_in_frame     = (state_q == ST_WAIT_FIFO) || (state_q == ST_ADDR) ||
                            (state_q == ST_DATA)      || (state_q == ST_RESP);
    // A sync edge coinciding with the final response starts the next frame.
    assign w_final_accept = (state_q == ST_RESP) & BVALID & w_last_burst;
    assign w_overrun_evt  = w_edge & w_in_frame & ~w_final_accept;
    assign w_bresp_evt    = (state_q == ST_RESP) & BVALID & (BRESP != 2'b00);

    for (genvar gi = 0; gi < PPB; gi++) begin : g_pix
        assign w_wdata_packed[gi*32 +: 32] = {8'd0, FIFO_DOUT[gi*24 +: 24]};
    end

    always_comb begin
        state_d      = state_q;
        bidx_d       = bidx_q;
        nburst_d     = nburst_q;
        beat_d       = beat_q;
        awaddr_d     = awaddr_q;
        cur_buf_d    = cur_buf_q;
        last_buf_d   = last_buf_q;
        frame_done_d = 1'b0;
        restart_d    = restart_q | w_overrun_evt;

        case (state_q)
            ST_IDLE: begin
                if (CAPON) state_d = ST_WAIT_VS;
            end
            ST_WAIT_VS: begin
                if (!CAPON) begin
                    state_d = ST_IDLE;
                end else if (w_edge) begin
                    nburst_d = w_nburst;
                    bidx_d   = '0;
                    state_d  = ST_WAIT_FIFO;
                end
            end
            ST_WAIT_FIFO: begin
                if ({1'b0, FIFO_DATA_CNT} >= C_FIFO_NEED) begin
                    awaddr_d = w_burst_addr;
                    beat_d   = 8'd0;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (AWREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (WREADY) begin
                    beat_d = beat_q + 8'd1;
                    if (beat_q == C_BEAT_LAST) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (BVALID) begin
                    if (restart_q || w_overrun_evt) begin
                        // Overrun: abandon this frame and refill the same buffer.
                        restart_d = 1'b0;
                        bidx_d    = '0;
                        nburst_d  = w_nburst;
                        state_d   = CAPON ? ST_WAIT_FIFO : ST_IDLE;
                    end else if (!w_last_burst) begin
                        bidx_d  = bidx_q + BIDX_W'(1);
                        state_d = ST_WAIT_FIFO;
                    end else begin
                        frame_done_d = 1'b1;
                        last_buf_d   = cur_buf_q;
                        cur_buf_d    = w_next_buf;
                        bidx_d       = '0;
                        if (!CAPON) begin
                            state_d = ST_IDLE;
                        end else if (w_edge) begin
                            nburst_d = w_nburst;
                            state_d  = ST_WAIT_FIFO;
                        end else begin
                            state_d = ST_WAIT_VS;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign overrun_d   = w_overrun_evt | (overrun_q & ~CLR_ERR);
    assign bresp_err_d = w_bresp_evt   | (bresp_err_q & ~CLR_ERR);

    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            state_q      <= ST_IDLE;
            bidx_q       <= '0;
            nburst_q     <= '0;
            beat_q       <= 8'd0;
            awaddr_q     <= '0;
            cur_buf_q    <= 2'd0;
            last_buf_q   <= 2'd0;
            frame_done_q <= 1'b0;
            restart_q    <= 1'b0;
            overrun_q    <= 1'b0;
            bresp_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bidx_q       <= bidx_d;
            nburst_q     <= nburst_d;
            beat_q       <= beat_d;
            awaddr_q     <= awaddr_d;
            cur_buf_q    <= cur_buf_d;
            last_buf_q   <= last_buf_d;
            frame_done_q <= frame_done_d;
            restart_q    <= restart_d;
            overrun_q    <= overrun_d;
            bresp_err_q  <= bresp_err_d;
        end
    end

    assign w_wvalid   = (state_q == ST_DATA);
    assign AWADDR     = awaddr_q;
    assign AWLEN      = C_BEAT_LAST;
    assign AWVALID    = (state_q == ST_ADDR);
    assign WDATA      = w_wvalid ? w_wdata_packed : '0;
    assign WSTRB      = '1;
    assign WVALID     = w_wvalid;
    assign WLAST      = w_wvalid & (beat_q == C_BEAT_LAST);
    assign BREADY     = (state_q == ST_RESP);
    assign FIFO_RD    = w_wvalid & WREADY;
    assign FRAME_DONE = frame_done_q;
    assign CUR_BUF    = cur_buf_q;
    assign LAST_BUF   = last_buf_q;
    assign BUSY       = (state_q != ST_IDLE);
    assign OVERRUN    = overrun_q;
    assign BRESP_ERR  = bresp_err_q;

endmodule
`default_nettype wire
